// File: rtl/flash_ctrl_pkg.sv
// Shared definitions for the GW1NR-9 user-flash sequencer.
// Holds op codes, FSM states, timer width and 27 MHz timing defaults.
package flash_ctrl_pkg;

  localparam int TMR_W = 22;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam int T_NVS_DEF   = 135;
  localparam int T_PGS_DEF   = 270;
  localparam int T_PROG_DEF  = 270;
  localparam int T_NVH_DEF   = 135;
  localparam int T_NVH1_DEF  = 2700;
  localparam int T_RCV_DEF   = 270;
  localparam int T_ERASE_DEF = 2700000;
  localparam int T_ACC_DEF   = 2;
  localparam int N_ROWS_DEF  = 304;

  typedef enum logic [3:0] {
    IDLE, RD_SETUP, RD_SE, RD_WAIT,
    PG_NVS, PG_PGS, PG_PROG, PG_ADH, PG_NVH, PG_RCV,
    ER_NVS, ER_ERASE, ER_NVH, ER_RCV,
    RESP, ERR
  } state_e;

  function automatic bit tmr_fits(input int v);
    return (v >= 1) && (v < (1 << TMR_W));
  endfunction

endpackage

// File: rtl/user_flash_ctrl_if.sv
// Command/response port between the SoC bus bridge (master) and the flash sequencer (slave).
interface user_flash_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [14:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/flash_ctrl_timer.sv
// Down-counter for sequencer wait states: load T-1 on state entry, done while the count is zero.
module flash_ctrl_timer
  import flash_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_value,
  output logic             o_done
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (i_load)         r_cnt <= i_value;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/user_flash_ctrl.sv
// GW1NR-9 user-flash sequencer: one READ/PROG/ERASE at a time, strobes registered off the state.
// cmd_ready only in IDLE (commands never queue); exactly one rsp_valid pulse per accepted command.
module user_flash_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int T_NVS   = T_NVS_DEF,
  parameter int T_PGS   = T_PGS_DEF,
  parameter int T_PROG  = T_PROG_DEF,
  parameter int T_NVH   = T_NVH_DEF,
  parameter int T_NVH1  = T_NVH1_DEF,
  parameter int T_RCV   = T_RCV_DEF,
  parameter int T_ERASE = T_ERASE_DEF,
  parameter int T_ACC   = T_ACC_DEF,
  parameter int N_ROWS  = N_ROWS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  user_flash_ctrl_if.slave  bus,
  output logic              busy,
  output logic              f_xe,
  output logic              f_ye,
  output logic              f_se,
  output logic              f_prog,
  output logic              f_erase,
  output logic              f_nvstr,
  output logic [8:0]        f_xadr,
  output logic [5:0]        f_yadr,
  output logic [31:0]       f_din,
  input  logic [31:0]       f_dout
);

  if (!tmr_fits(T_NVS) || !tmr_fits(T_PGS) || !tmr_fits(T_PROG) || !tmr_fits(T_NVH) ||
      !tmr_fits(T_NVH1) || !tmr_fits(T_RCV) || !tmr_fits(T_ERASE) || !tmr_fits(T_ACC) ||
      N_ROWS < 1 || N_ROWS > 512) begin : g_bad_param
    $error("user_flash_ctrl: timing parameter outside [1, 2^22) or N_ROWS outside [1, 512]");
  end

  state_e           r_state, w_state_nxt;
  logic             r_err;
  logic             w_accept, w_bad;
  logic             w_tmr_load, w_tmr_done;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_xe, w_ye, w_se, w_prog, w_erase, w_nvstr, w_rsp_vld;

  function automatic logic [TMR_W-1:0] ticks(input state_e s);
    case (s)
      RD_WAIT:        return TMR_W'(T_ACC - 1);
      PG_NVS, ER_NVS: return TMR_W'(T_NVS - 1);
      PG_PGS:         return TMR_W'(T_PGS - 1);
      PG_PROG:        return TMR_W'(T_PROG - 1);
      PG_NVH:         return TMR_W'(T_NVH - 1);
      PG_RCV, ER_RCV: return TMR_W'(T_RCV - 1);
      ER_ERASE:       return TMR_W'(T_ERASE - 1);
      ER_NVH:         return TMR_W'(T_NVH1 - 1);
      default:        return '0;
    endcase
  endfunction

  assign w_accept = (r_state == IDLE) && bus.cmd_ready && bus.cmd_valid;
  assign w_bad    = (bus.cmd_op == OP_RSVD) || ({1'b0, bus.cmd_addr[14:6]} >= 10'(N_ROWS));

  // Timer reloads on every state change; single-cycle states simply ignore it.
  assign w_tmr_load = (w_state_nxt != r_state);
  assign w_tmr_val  = ticks(w_state_nxt);

  flash_ctrl_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_done  (w_tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (w_bad)                      w_state_nxt = ERR;
        else if (bus.cmd_op == OP_READ) w_state_nxt = RD_SETUP;
        else if (bus.cmd_op == OP_PROG) w_state_nxt = PG_NVS;
        else                            w_state_nxt = ER_NVS;
      end
      RD_SETUP: w_state_nxt = RD_SE;
      RD_SE:    w_state_nxt = RD_WAIT;
      RD_WAIT:  if (w_tmr_done) w_state_nxt = RESP;
      PG_NVS:   if (w_tmr_done) w_state_nxt = PG_PGS;
      PG_PGS:   if (w_tmr_done) w_state_nxt = PG_PROG;
      PG_PROG:  if (w_tmr_done) w_state_nxt = PG_ADH;
      PG_ADH:   w_state_nxt = PG_NVH;
      PG_NVH:   if (w_tmr_done) w_state_nxt = PG_RCV;
      PG_RCV:   if (w_tmr_done) w_state_nxt = RESP;
      ER_NVS:   if (w_tmr_done) w_state_nxt = ER_ERASE;
      ER_ERASE: if (w_tmr_done) w_state_nxt = ER_NVH;
      ER_NVH:   if (w_tmr_done) w_state_nxt = ER_RCV;
      ER_RCV:   if (w_tmr_done) w_state_nxt = RESP;
      ERR:      w_state_nxt = RESP;
      RESP:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_xe = 1'b0; w_ye = 1'b0; w_se = 1'b0;
    w_prog = 1'b0; w_erase = 1'b0; w_nvstr = 1'b0; w_rsp_vld = 1'b0;
    case (r_state)
      RD_SETUP, RD_WAIT: begin w_xe = 1'b1; w_ye = 1'b1; end
      RD_SE:    begin w_xe = 1'b1; w_ye = 1'b1; w_se = 1'b1; end
      PG_NVS:   begin w_xe = 1'b1; w_prog = 1'b1; end
      PG_PGS, PG_ADH: begin w_xe = 1'b1; w_prog = 1'b1; w_nvstr = 1'b1; end
      PG_PROG:  begin w_xe = 1'b1; w_prog = 1'b1; w_nvstr = 1'b1; w_ye = 1'b1; end
      PG_NVH, ER_NVH: begin w_xe = 1'b1; w_nvstr = 1'b1; end
      ER_NVS:   begin w_xe = 1'b1; w_erase = 1'b1; end
      ER_ERASE: begin w_xe = 1'b1; w_erase = 1'b1; w_nvstr = 1'b1; end
      RESP:     w_rsp_vld = 1'b1;
      default:  ;
    endcase
  end

  // Strobes and response lag the state by one cycle so every pin leaves a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_xe <= 1'b0; f_ye <= 1'b0; f_se <= 1'b0;
      f_prog <= 1'b0; f_erase <= 1'b0; f_nvstr <= 1'b0;
      f_xadr <= '0; f_yadr <= '0; f_din <= '0;
      bus.cmd_ready <= 1'b0; bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0; bus.rsp_err <= 1'b0;
      busy <= 1'b0; r_err <= 1'b0;
    end else begin
      f_xe <= w_xe; f_ye <= w_ye; f_se <= w_se;
      f_prog <= w_prog; f_erase <= w_erase; f_nvstr <= w_nvstr;
      bus.cmd_ready <= (w_state_nxt == IDLE);
      busy          <= (w_state_nxt != IDLE);
      bus.rsp_valid <= w_rsp_vld;
      bus.rsp_err   <= w_rsp_vld & r_err;
      if (w_accept) begin
        f_xadr <= bus.cmd_addr[14:6];
        f_yadr <= bus.cmd_addr[5:0];
        f_din  <= bus.cmd_wdata;
        r_err  <= w_bad;
      end
      if (r_state == RD_WAIT && w_tmr_done) bus.rsp_rdata <= f_dout;
    end
  end

  a_prog_erase_excl: assert property (@(posedge clk) disable iff (!rst_n) !(f_prog && f_erase));
  a_ye_in_prog: assert property (@(posedge clk) disable iff (!rst_n)
    (f_prog && f_ye) |-> ($past(r_state) == PG_PROG));
  a_se_in_rd_se: assert property (@(posedge clk) disable iff (!rst_n)
    f_se |-> ($past(r_state) == RD_SE));
  a_nvstr_guard: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(f_nvstr) |-> $past(f_prog || f_erase));

endmodule

// File: tb/tb_user_flash_ctrl.sv
// Directed bench for user_flash_ctrl with a behavioural flash array model and edge timestamping.
module tb_user_flash_ctrl;
  import flash_ctrl_pkg::*;

  logic        clk, rst_n;
  logic        busy, f_xe, f_ye, f_se, f_prog, f_erase, f_nvstr;
  logic [8:0]  f_xadr;
  logic [5:0]  f_yadr;
  logic [31:0] f_din, f_dout;
  logic [31:0] mem [0:32767];

  user_flash_ctrl_if bus ();

  user_flash_ctrl #(.T_ERASE(1000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .f_xe(f_xe), .f_ye(f_ye), .f_se(f_se), .f_prog(f_prog), .f_erase(f_erase),
    .f_nvstr(f_nvstr), .f_xadr(f_xadr), .f_yadr(f_yadr), .f_din(f_din), .f_dout(f_dout)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int n_vec = 0, n_miss = 0;
  int cyc = 0;
  int t_prog_r, t_prog_f, t_nv_r, t_nv_f, t_ye_r, t_ye_f, t_er_r, t_er_f, t_rsp;
  int se_cnt = 0, strobe_cnt = 0, rsp_cnt = 0;
  logic q_prog = 0, q_nv = 0, q_ye = 0, q_er = 0;
  logic [31:0] m_rdata;
  logic        m_err;

  always @(posedge clk) cyc <= cyc + 1;

  assign f_dout = (f_xe && f_ye) ? mem[{f_xadr, f_yadr}] : 32'h0;

  // Flash array: program ANDs data in on YE rise, erase sets the addressed row to all-ones.
  initial begin
    logic m_ye_q;
    m_ye_q = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 32'hFFFF_FFFF;
    mem[15'h0041] = 32'hDEAD_BEEF;
    mem[15'h0143] = 32'h0000_0000;
    forever begin
      @(negedge clk);
      if (f_xe && f_prog && f_nvstr && f_ye && !m_ye_q) mem[{f_xadr, f_yadr}] &= f_din;
      if (f_xe && f_erase && f_nvstr)
        for (int y = 0; y < 64; y++) mem[{f_xadr, 6'(y)}] = 32'hFFFF_FFFF;
      m_ye_q = f_ye;
    end
  end

  always @(negedge clk) begin
    if (f_prog && !q_prog)   t_prog_r <= cyc;
    if (!f_prog && q_prog)   t_prog_f <= cyc;
    if (f_nvstr && !q_nv)    t_nv_r <= cyc;
    if (!f_nvstr && q_nv)    t_nv_f <= cyc;
    if (f_ye && !q_ye)       t_ye_r <= cyc;
    if (!f_ye && q_ye)       t_ye_f <= cyc;
    if (f_erase && !q_er)    t_er_r <= cyc;
    if (!f_erase && q_er)    t_er_f <= cyc;
    if (f_se) se_cnt <= se_cnt + 1;
    if (f_xe || f_ye || f_se || f_prog || f_erase || f_nvstr) strobe_cnt <= strobe_cnt + 1;
    if (bus.rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1; t_rsp <= cyc; m_rdata <= bus.rsp_rdata; m_err <= bus.rsp_err;
    end
    q_prog <= f_prog; q_nv <= f_nvstr; q_ye <= f_ye; q_er <= f_erase;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [14:0] addr, input logic [31:0] wd,
                      output int acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_wdata = wd;
    while (!bus.cmd_ready && n < 10000) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) check_eq("accept_timeout", 32'h0, 32'h1);
    @(negedge clk);
    acc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int c0, input string tag);
    int n;
    n = 0;
    while (rsp_cnt == c0 && n < 8000) begin @(negedge clk); n++; end
    if (rsp_cnt == c0) check_eq(tag, 32'h0, 32'h1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int acc, acc2, c0, s0, n;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_READ; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(bus.cmd_ready), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_strobes", 32'({f_xe, f_ye, f_se, f_prog, f_erase, f_nvstr, bus.rsp_valid}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(bus.cmd_ready), 32'h1);

    // READ 0x0041 -> row 1, column 1
    c0 = rsp_cnt; s0 = se_cnt;
    send(OP_READ, 15'h0041, 32'h0, acc);
    check_eq("rd_xadr", 32'(f_xadr), 32'h1);
    check_eq("rd_yadr", 32'(f_yadr), 32'h1);
    check_eq("rd_busy", 32'(busy), 32'h1);
    wait_rsp(c0, "rd_rsp_timeout");
    check_eq("rd_latency", t_rsp - acc, 32'd5);
    check_eq("rd_data", m_rdata, 32'hDEAD_BEEF);
    check_eq("rd_err", 32'(m_err), 32'h0);
    check_eq("rd_se_cycles", se_cnt - s0, 32'd1);
    check_eq("rd_one_rsp", rsp_cnt - c0, 32'd1);

    // Out-of-range row and reserved op
    c0 = rsp_cnt; s0 = strobe_cnt;
    send(OP_PROG, 15'h7FC0, 32'h0, acc);
    wait_rsp(c0, "err_rsp_timeout");
    check_eq("err_latency", t_rsp - acc, 32'd2);
    check_eq("err_flag", 32'(m_err), 32'h1);
    check_eq("err_no_strobe", strobe_cnt - s0, 32'd0);
    check_eq("err_rdata_held", m_rdata, 32'hDEAD_BEEF);
    c0 = rsp_cnt;
    send(OP_RSVD, 15'h0000, 32'h0, acc);
    wait_rsp(c0, "rsvd_rsp_timeout");
    check_eq("rsvd_latency", t_rsp - acc, 32'd2);
    check_eq("rsvd_flag", 32'(m_err), 32'h1);

    // PROG 0x0100
    c0 = rsp_cnt;
    send(OP_PROG, 15'h0100, 32'h1234_5678, acc);
    wait_rsp(c0, "pg_rsp_timeout");
    check_eq("pg_prog_rise", t_prog_r - acc, 32'd1);
    check_eq("pg_nvs", t_nv_r - t_prog_r, 32'd135);
    check_eq("pg_pgs", t_ye_r - t_nv_r, 32'd270);
    check_eq("pg_ye_high", t_ye_f - t_ye_r, 32'd270);
    check_eq("pg_nvh", t_nv_f - t_prog_f, 32'd135);
    check_eq("pg_rcv", t_rsp - t_nv_f, 32'd270);
    check_eq("pg_latency", t_rsp - acc, 32'd1082);
    check_eq("pg_err", 32'(m_err), 32'h0);
    check_eq("pg_mem", mem[15'h0100], 32'h1234_5678);
    check_eq("pg_one_rsp", rsp_cnt - c0, 32'd1);

    // ERASE row 5, then read a word of that row back
    c0 = rsp_cnt;
    send(OP_ERASE, 15'h0140, 32'h0, acc);
    wait_rsp(c0, "er_rsp_timeout");
    check_eq("er_erase_high", t_er_f - t_er_r, 32'd1135);
    check_eq("er_nvh1", t_nv_f - t_er_f, 32'd2700);
    check_eq("er_latency", t_rsp - acc, 32'd4106);
    c0 = rsp_cnt;
    send(OP_READ, 15'h0143, 32'h0, acc);
    wait_rsp(c0, "er_rd_timeout");
    check_eq("er_readback", m_rdata, 32'hFFFF_FFFF);

    // cmd_valid held through a PROG: the follow-on READ waits for the response
    c0 = rsp_cnt;
    send(OP_PROG, 15'h0101, 32'hA5A5_A5A5, acc);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_READ; bus.cmd_addr = 15'h0101;
    n = 0;
    while (!bus.cmd_ready && n < 3000) begin @(negedge clk); n++; end
    check_eq("hold_rsp_with_ready", 32'(bus.rsp_valid), 32'h1);
    @(negedge clk);
    acc2 = cyc;
    bus.cmd_valid = 1'b0;
    check_eq("hold_accept_after_rsp", acc2 - t_rsp, 32'd1);
    wait_rsp(c0 + 1, "hold_rd_timeout");
    check_eq("hold_rd_data", m_rdata, 32'hA5A5_A5A5);
    check_eq("hold_two_rsp", rsp_cnt - c0, 32'd2);

    // Reset in the middle of PG_PROG
    c0 = rsp_cnt;
    send(OP_PROG, 15'h0102, 32'h0, acc);
    n = 0;
    while (!f_ye && n < 1000) begin @(negedge clk); n++; end
    check_eq("mid_ye_seen", 32'(f_ye), 32'h1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_strobes", 32'({f_xe, f_ye, f_se, f_prog, f_erase, f_nvstr}), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_ready_after", 32'(bus.cmd_ready), 32'h1);
    repeat (20) @(negedge clk);
    check_eq("mid_no_rsp", rsp_cnt - c0, 32'd0);
    c0 = rsp_cnt;
    send(OP_READ, 15'h0100, 32'h0, acc);
    wait_rsp(c0, "post_rst_rd_timeout");
    check_eq("post_rst_rd", m_rdata, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
